spi_main: RTL and testbench

Controller (main) end of the project's SPI link: serialises one word of configurable width on `sck`/`out_bit` while capturing the secondary's reply on `in_bit`, in SPI mode 0 (sck idle low, data changed on falling edge, captured by the secondary on rising edge). It sits between on-chip logic that issues words (start/done handshake) and the SPI pins of an external or on-chip `spi_secondary`-style device. Chip select is active-low and may be held across consecutive words for multi-word frames.

---
 rtl/spi_main.sv | 122 ++++++++++++
 tb/tb_spi_main.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_main.sv
// SPI mode-0 controller: shifts one WordBits-wide word out MSB first on sck/out_bit
// while capturing the secondary's reply from in_bit; cs may be held across words.
module spi_main #(
    parameter int unsigned WordBits = 8,
    parameter int unsigned ClkDiv   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WordBits-1:0] tx_word,
    input  logic                hold_cs,
    output logic                busy,
    output logic                done,
    output logic [WordBits-1:0] rx_word,
    output logic                sck,
    output logic                out_bit,
    input  logic                in_bit,
    output logic                cs
);

    localparam int unsigned DivW = $clog2(ClkDiv);
    localparam int unsigned BitW = $clog2(WordBits + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(WordBits - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } state_t;

    state_t              state;
    logic [DivW-1:0]     div_cnt;
    logic [BitW-1:0]     bit_cnt;
    logic [WordBits-1:0] tx_sh;
    logic [WordBits-1:0] rx_sh;
    logic                hold_q;
    logic                div_end_c;

    assign div_end_c = (div_cnt == DivLast);

    // Every non-idle phase lasts exactly ClkDiv cycles; the FSM acts on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            hold_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_word <= '0;
            sck     <= 1'b0;
            out_bit <= 1'b0;
            cs      <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= div_end_c ? '0 : div_cnt + DivW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh   <= tx_word;
                        out_bit <= tx_word[WordBits-1];
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        hold_q  <= hold_cs;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= LEAD;
                    end else if (!cs && !hold_cs) begin
                        cs <= 1'b1;
                    end
                end
                LEAD: begin
                    if (div_end_c) begin
                        sck   <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    // Falling sck: capture the reply bit, then present the next data bit.
                    if (div_end_c) begin
                        sck     <= 1'b0;
                        rx_sh   <= {rx_sh[WordBits-2:0], in_bit};
                        bit_cnt <= bit_cnt + BitW'(1);
                        if (bit_cnt == BitLast) begin
                            state <= TRAIL;
                        end else begin
                            tx_sh   <= tx_sh << 1;
                            out_bit <= tx_sh[WordBits-2];
                            state   <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (div_end_c) begin
                        sck   <= 1'b1;
                        state <= HIGH;
                    end
                end
                TRAIL: begin
                    if (div_end_c) begin
                        rx_word <= rx_sh;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cs      <= !hold_q;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_main.sv
// Scoreboard bench for spi_main: default instance (loopback or secondary model)
// plus a WordBits=16/ClkDiv=2 loopback instance.
module tb_spi_main;

    typedef struct {
        logic [15:0] rx;
        int          cyc;
        logic        cs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic       start0, hold0, busy0, done0, sck0, out0, in0, cs0, loop0;
    logic [7:0] tx0, rx0;

    // wide/fast instance
    logic        start1, hold1, busy1, done1, sck1, out1, cs1;
    logic [15:0] tx1, rx1;

    spi_main #(.WordBits(8), .ClkDiv(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .tx_word(tx0), .hold_cs(hold0),
        .busy(busy0), .done(done0), .rx_word(rx0), .sck(sck0), .out_bit(out0),
        .in_bit(in0), .cs(cs0)
    );

    spi_main #(.WordBits(16), .ClkDiv(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_word(tx1), .hold_cs(hold1),
        .busy(busy1), .done(done1), .rx_word(rx1), .sck(sck1), .out_bit(out1),
        .in_bit(out1), .cs(cs1)
    );

    // Mode-0 secondary: loads on cs fall, shifts out on sck fall, captures on sck rise.
    logic [7:0] sec_load = 8'h00;
    logic [7:0] sec_tx = 8'h00;
    logic [7:0] sec_rx = 8'h00;
    logic       sec_armed = 1'b0;

    always @(negedge cs0 or negedge sck0 or posedge cs0) begin
        if (cs0) begin
            sec_armed = 1'b0;
        end else if (!sec_armed) begin
            sec_tx    = sec_load;
            sec_armed = 1'b1;
        end else begin
            sec_tx = sec_tx << 1;
        end
    end

    always @(posedge sck0) if (!cs0) sec_rx = {sec_rx[6:0], out0};

    assign in0 = loop0 ? out0 : sec_tx[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Edge counters sampled on the inactive clock edge.
    int   pulses0 = 0, pulses1 = 0, cs_rises = 0, first1 = 0, last1 = 0;
    logic sck0_q = 1'b0, sck1_q = 1'b0, cs0_q = 1'b1;

    always @(negedge clk) begin
        if (sck0 && !sck0_q) pulses0++;
        if (cs0 && !cs0_q) cs_rises++;
        if (sck1 && !sck1_q) begin
            if (pulses1 == 0) first1 = cyc;
            last1 = cyc;
            pulses1++;
        end
        sck0_q = sck0;
        sck1_q = sck1;
        cs0_q  = cs0;
    end

    // Scoreboard monitor: every done pops one expectation.
    exp_t q0[$];
    exp_t q1[$];

    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) begin
                chk("done0_unexpected", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("rx0_word", 32'(rx0), 32'(e.rx));
                chk("done0_cycle", 32'(cyc), 32'(e.cyc));
                chk("cs0_at_done", 32'(cs0), 32'(e.cs));
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                chk("done1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("rx1_word", 32'(rx1), 32'(e.rx));
                chk("done1_cycle", 32'(cyc), 32'(e.cyc));
                chk("cs1_at_done", 32'(cs1), 32'(e.cs));
            end
        end
    end

    // Called just after a negedge; accept happens on the next posedge.
    task automatic send0(input logic [7:0] tx, input logic h, input logic [7:0] er,
                         input logic ecs);
        exp_t e;
        e.rx  = 16'(er);
        e.cyc = cyc + 1 + 68;
        e.cs  = ecs;
        q0.push_back(e);
        tx0    = tx;
        hold0  = h;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done0) return;
        end
        chk("timeout_done0", 32'd0, 32'd1);
    endtask

    task automatic wait_done1(input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done1) return;
        end
        chk("timeout_done1", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        exp_t e;
        rst_n  = 1'b0;
        start0 = 1'b0; tx0 = 8'h00; hold0 = 1'b0; loop0 = 1'b1;
        start1 = 1'b0; tx1 = 16'h0000; hold1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(sck0), 32'd0);
        chk("rst_cs", 32'(cs0), 32'd1);
        chk("rst_out_bit", 32'(out0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_rx_word", 32'(rx0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single word, loopback
        base = pulses0;
        send0(8'hA5, 1'b0, 8'hA5, 1'b1);
        chk("a5_busy", 32'(busy0), 32'd1);
        chk("a5_cs_low", 32'(cs0), 32'd0);
        wait_done0(200);
        chk("a5_pulses", 32'(pulses0 - base), 32'd8);
        chk("a5_out_pattern", 32'(sec_rx), 32'hA5);
        @(negedge clk);
        chk("a5_cs_idle", 32'(cs0), 32'd1);

        // reset in the middle of the first sck-high phase
        tx0 = 8'h5A; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_sck", 32'(sck0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sck", 32'(sck0), 32'd0);
        chk("abort_cs", 32'(cs0), 32'd1);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_rx_word", 32'(rx0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_abort_busy", 32'(busy0), 32'd0);
        chk("post_abort_rx_word", 32'(rx0), 32'd0);

        // against the secondary model
        loop0 = 1'b0; sec_load = 8'h3C;
        send0(8'hC3, 1'b0, 8'h3C, 1'b1);
        wait_done0(200);
        chk("sec_received", 32'(sec_rx), 32'hC3);
        loop0 = 1'b1;
        @(negedge clk);

        // start while busy is ignored
        send0(8'h5A, 1'b0, 8'h5A, 1'b1);
        repeat (9) @(negedge clk);
        chk("ignore_busy", 32'(busy0), 32'd1);
        tx0 = 8'hFF; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(200);
        chk("ignore_sent_word", 32'(sec_rx), 32'h5A);
        repeat (80) @(negedge clk);
        chk("ignore_queue_empty", 32'(q0.size()), 32'd0);
        chk("ignore_idle", 32'(busy0), 32'd0);

        // back-to-back with held cs
        base = pulses0;
        cs_rises = cs_rises;
        begin
            int rise_base;
            rise_base = cs_rises;
            send0(8'h12, 1'b1, 8'h12, 1'b0);
            wait_done0(200);
            chk("b2b_busy_gap", 32'(busy0), 32'd0);
            send0(8'h34, 1'b1, 8'h34, 1'b0);
            chk("b2b_busy_again", 32'(busy0), 32'd1);
            wait_done0(200);
            chk("b2b_pulses", 32'(pulses0 - base), 32'd16);
            chk("b2b_cs_rises", 32'(cs_rises - rise_base), 32'd0);
            chk("b2b_cs_held", 32'(cs0), 32'd0);
        end
        hold0 = 1'b0;
        @(negedge clk);
        chk("b2b_cs_release", 32'(cs0), 32'd1);

        // wide word, fast divider, loopback
        e.rx = 16'h8001; e.cyc = cyc + 1 + 66; e.cs = 1'b1;
        q1.push_back(e);
        tx1 = 16'h8001; hold1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(200);
        chk("w16_pulses", 32'(pulses1), 32'd16);
        chk("w16_period_span", 32'(last1 - first1), 32'd60);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
